// File: rtl/r4_bfly_pkg.sv
// Shared types and constants for the radix-4 butterfly sequencer.
// Slot k of a packed group occupies bits [k*DW +: DW].
package r4_bfly_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    CAP,
    OUT
  } state_e;

  localparam int NPT = 4;
  localparam int CW  = 3;

  function automatic int slot_lsb(input int k, input int dw);
    return k * dw;
  endfunction

endpackage

// File: rtl/r4_bfly_collect.sv
// Serial-to-parallel capture of the butterfly's X0..X3 outputs.
// One real/imag pair is written per enabled cycle into the slot given by slot_i.
module r4_bfly_collect
  import r4_bfly_pkg::*;
#(
  parameter int DW = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [1:0]        slot_i,
  input  logic [DW-1:0]     d_r_i,
  input  logic [DW-1:0]     d_i_i,
  output logic [NPT*DW-1:0] q_r_o,
  output logic [NPT*DW-1:0] q_i_o
);

  logic [NPT*DW-1:0] q_r_q;
  logic [NPT*DW-1:0] q_i_q;

  // NOTE: the slots are plain flops, not RAM, so they can be reset; they must read 0 after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_r_q <= '0;
      q_i_q <= '0;
    end else if (we_i) begin
      q_r_q[slot_lsb(int'(slot_i), DW) +: DW] <= d_r_i;
      q_i_q[slot_lsb(int'(slot_i), DW) +: DW] <= d_i_i;
    end
  end

  assign q_r_o = q_r_q;
  assign q_i_o = q_i_q;

endmodule

// File: rtl/r4_bfly_seq.sv
// Sequencer feeding the radix-4 butterfly one 4-point group at a time:
// holds the group on bf_*, collects the serial X0..X3 results, hands them downstream.
module r4_bfly_seq
  import r4_bfly_pkg::*;
#(
  parameter int DW       = 4,
  parameter int BFLY_LAT = 2,
  parameter int NPT      = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NPT*DW-1:0] in_xr,
  input  logic [NPT*DW-1:0] in_xi,
  input  logic [CW-1:0]     in_c,
  output logic [NPT*DW-1:0] bf_xr,
  output logic [NPT*DW-1:0] bf_xi,
  output logic [CW-1:0]     bf_c,
  input  logic [DW-1:0]     bf_xro,
  input  logic [DW-1:0]     bf_xio,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [NPT*DW-1:0] out_xr,
  output logic [NPT*DW-1:0] out_xi,
  output logic              busy,
  output logic [7:0]        grp_cnt
);

  localparam logic [3:0] WCNT_INIT = 4'(BFLY_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [1:0]        kcnt_q, kcnt_d;
  logic [7:0]        grp_cnt_q, grp_cnt_d;
  logic [NPT*DW-1:0] bf_xr_q, bf_xi_q;
  logic [CW-1:0]     bf_c_q;
  logic              accept;
  logic              cap_we;

  // NOTE: every signal gets its default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    kcnt_d    = kcnt_q;
    grp_cnt_d = grp_cnt_q;
    accept    = 1'b0;
    cap_we    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          wcnt_d  = WCNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (wcnt_q == 4'd0) begin
          kcnt_d  = 2'd0;
          state_d = CAP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      CAP: begin
        cap_we = 1'b1;
        kcnt_d = kcnt_q + 2'd1;
        if (kcnt_q == 2'd3) state_d = OUT;
      end
      OUT: begin
        if (out_ready) begin
          grp_cnt_d = grp_cnt_q + 8'd1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      kcnt_q    <= '0;
      grp_cnt_q <= '0;
      bf_xr_q   <= '0;
      bf_xi_q   <= '0;
      bf_c_q    <= '0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      kcnt_q    <= kcnt_d;
      grp_cnt_q <= grp_cnt_d;
      if (accept) begin
        bf_xr_q <= in_xr;
        bf_xi_q <= in_xi;
        bf_c_q  <= in_c;
      end
    end
  end

  r4_bfly_collect #(
    .DW(DW)
  ) u_collect (
    .clk_i (CLK),
    .rst_i (RST),
    .we_i  (cap_we),
    .slot_i(kcnt_q),
    .d_r_i (bf_xro),
    .d_i_i (bf_xio),
    .q_r_o (out_xr),
    .q_i_o (out_xi)
  );

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == OUT);
  assign grp_cnt   = grp_cnt_q;
  assign bf_xr     = bf_xr_q;
  assign bf_xi     = bf_xi_q;
  assign bf_c      = bf_c_q;

endmodule

// File: tb/tb_r4_bfly_seq.sv
// Bench for r4_bfly_seq: a transaction-level model predicts handshakes, held values and
// captured results; the butterfly is emulated by a per-cycle source table.
module tb_r4_bfly_seq;

  localparam int DW   = 4;
  localparam int LAT  = 2;
  localparam int NPT  = 4;
  localparam int W    = NPT * DW;
  localparam int NCYC = 4096;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid, in_ready;
  logic [W-1:0]  in_xr, in_xi;
  logic [2:0]    in_c;
  logic [W-1:0]  bf_xr, bf_xi;
  logic [2:0]    bf_c;
  logic [DW-1:0] bf_xro, bf_xio;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_xr, out_xi;
  logic          busy;
  logic [7:0]    grp_cnt;

  r4_bfly_seq #(.DW(DW), .BFLY_LAT(LAT), .NPT(NPT)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_xr(in_xr), .in_xi(in_xi), .in_c(in_c),
    .bf_xr(bf_xr), .bf_xi(bf_xi), .bf_c(bf_c),
    .bf_xro(bf_xro), .bf_xio(bf_xio),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_xr(out_xr), .out_xi(out_xi),
    .busy(busy), .grp_cnt(grp_cnt)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  // Emulated butterfly output stream, indexed by cycle.
  logic [DW-1:0] src_r [NCYC];
  logic [DW-1:0] src_i [NCYC];

  // Reference model state.
  bit           m_inflight;
  int           m_acc;
  int           m_grp;
  int           m_done;
  logic [W-1:0] m_bfr, m_bfi;
  logic [2:0]   m_bfc;
  logic [W-1:0] m_newr, m_newi, m_lastr, m_lasti;

  typedef struct {
    logic [W-1:0] xr, xi;
    logic [2:0]   c;
    logic [W-1:0] seq_r, seq_i;  // serial outputs in time order, first emitted in the MSBs
    logic [W-1:0] exp_r, exp_i;
  } vec_t;

  vec_t vecs [3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  function automatic logic [W-1:0] result_of(input int t, input bit imag);
    logic [W-1:0] v;
    for (int k = 0; k < NPT; k++)
      v[k*DW +: DW] = imag ? src_i[(t + 1 + LAT + k) % NCYC] : src_r[(t + 1 + LAT + k) % NCYC];
    return v;
  endfunction

  task automatic model_reset();
    m_inflight = 0; m_acc = 0; m_grp = 0;
    m_bfr = '0; m_bfi = '0; m_bfc = '0;
    m_newr = '0; m_newi = '0; m_lastr = '0; m_lasti = '0;
  endtask

  // One clock cycle: drive butterfly outputs, compare against model, advance model and clock.
  task automatic tick();
    bit exp_ov;
    bf_xro = src_r[cyc % NCYC];
    bf_xio = src_i[cyc % NCYC];
    exp_ov = m_inflight && (cyc >= m_acc + LAT + 5);
    check("in_ready", in_ready, !m_inflight);
    check("out_valid", out_valid, exp_ov);
    check("busy", busy, m_inflight);
    check("grp_cnt", grp_cnt, m_grp[7:0]);
    check("bf_xr", bf_xr, m_bfr);
    check("bf_xi", bf_xi, m_bfi);
    check("bf_c", bf_c, m_bfc);
    if (exp_ov) begin
      check("out_xr", out_xr, m_newr);
      check("out_xi", out_xi, m_newi);
    end else if (!m_inflight || cyc < m_acc + LAT + 2) begin
      check("out_xr_hold", out_xr, m_lastr);
      check("out_xi_hold", out_xi, m_lasti);
    end
    if (RST) begin
      model_reset();
    end else if (!m_inflight) begin
      if (in_valid) begin
        m_inflight = 1; m_acc = cyc;
        m_bfr = in_xr; m_bfi = in_xi; m_bfc = in_c;
        m_newr = result_of(cyc, 0); m_newi = result_of(cyc, 1);
      end
    end else if (exp_ov && out_ready) begin
      m_inflight = 0;
      m_grp = (m_grp + 1) % 256;
      m_done++;
      m_lastr = m_newr; m_lasti = m_newi;
    end
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic rand_inputs();
    in_xr = W'($urandom); in_xi = W'($urandom); in_c = 3'($urandom);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int t, n;
    in_valid = 0; out_ready = 0;
    n = 0;
    while (in_ready !== 1'b1 && n < 40) begin tick(); n++; end
    t = cyc;
    for (int k = 0; k < NPT; k++) begin
      src_r[(t + 1 + LAT + k) % NCYC] = v.seq_r[(NPT-1-k)*DW +: DW];
      src_i[(t + 1 + LAT + k) % NCYC] = v.seq_i[(NPT-1-k)*DW +: DW];
    end
    in_valid = 1; in_xr = v.xr; in_xi = v.xi; in_c = v.c;
    tick();
    in_valid = 0; rand_inputs();
    check({tag, "_bf_xr"}, bf_xr, v.xr);
    check({tag, "_bf_c"}, bf_c, v.c);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    check({tag, "_latency"}, cyc - t, LAT + 5);
    check({tag, "_out_xr"}, out_xr, v.exp_r);
    check({tag, "_out_xi"}, out_xi, v.exp_i);
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, g0;
    int acc_q [$];
    logic [W-1:0] pend_r;

    vecs[0] = '{xr: 16'h4321, xi: 16'h8765, c: 3'b101, seq_r: 16'h1234, seq_i: 16'h9ABC,
                exp_r: 16'h4321, exp_i: 16'hCBA9};
    vecs[1] = '{xr: 16'hA5F0, xi: 16'h0F0F, c: 3'b010, seq_r: 16'hF0A5, seq_i: 16'h0001,
                exp_r: 16'h5A0F, exp_i: 16'h1000};
    vecs[2] = '{xr: 16'hFFFF, xi: 16'h0000, c: 3'b111, seq_r: 16'h8421, seq_i: 16'h7E3C,
                exp_r: 16'h1248, exp_i: 16'hC3E7};

    for (int i = 0; i < NCYC; i++) begin
      src_r[i] = DW'($urandom); src_i[i] = DW'($urandom);
    end

    // Reset and idle state
    RST = 1; in_valid = 0; out_ready = 0; in_xr = '0; in_xi = '0; in_c = '0;
    bf_xro = '0; bf_xio = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 0;
    model_reset();
    m_done = 0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grp_cnt", grp_cnt, 8'd0);
    check("rst_bf_xr", bf_xr, 16'h0);
    check("rst_bf_c", bf_c, 3'b0);
    check("rst_out_xr", out_xr, 16'h0);

    // Directed single groups
    while (cyc < 10) tick();
    for (int i = 0; i < 3; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
    check("vec_grp_cnt", grp_cnt, 8'd3);

    // Backpressure: hold out_ready low for 20 cycles with a pending in_valid
    rand_inputs(); in_valid = 1; out_ready = 0;
    tick();
    pend_r = 16'hBEEF; in_xr = pend_r;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    repeat (20) tick();
    check("bp_in_ready", in_ready, 1'b0);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("bp_ready_after", in_ready, 1'b1);
    tick();
    check("bp_accept", bf_xr, pend_r);
    in_valid = 0; out_ready = 1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin tick(); n++; end

    // Back-to-back: in_valid held high, out_ready high
    in_valid = 1; out_ready = 1;
    n = 0;
    while (acc_q.size() < 3 && n < 60) begin
      if (!m_inflight) rand_inputs();
      if (in_ready === 1'b1) acc_q.push_back(cyc);
      tick(); n++;
    end
    check("b2b_accepts", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      check("b2b_gap1", acc_q[1] - acc_q[0], LAT + 6);
      check("b2b_gap2", acc_q[2] - acc_q[1], LAT + 6);
    end
    in_valid = 0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin tick(); n++; end

    // Reset at the second capture cycle
    out_ready = 0; rand_inputs(); in_valid = 1;
    g0 = cyc;
    tick();
    in_valid = 0;
    while (cyc < g0 + 1 + LAT + 1) tick();
    RST = 1;
    tick();
    RST = 0;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_grp_cnt", grp_cnt, 8'd0);
    check("mid_rst_out_xr", out_xr, 16'h0);
    check("mid_rst_bf_xr", bf_xr, 16'h0);
    run_vec(vecs[0], "post_rst");
    check("post_rst_grp_cnt", grp_cnt, 8'd1);

    // Wrap: 256 groups with random handshakes, then one more
    RST = 1;
    tick();
    RST = 0;
    m_done = 0;
    n = 0;
    while (m_done < 256 && n < 20000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if (!m_inflight) rand_inputs();
      tick(); n++;
    end
    check("wrap_done", m_done, 256);
    check("wrap_grp0", grp_cnt, 8'd0);
    while (m_done < 257 && n < 20000) begin
      in_valid  = 1;
      out_ready = ($urandom_range(0, 1) != 0);
      if (!m_inflight) rand_inputs();
      tick(); n++;
    end
    check("wrap_grp1", grp_cnt, 8'd1);
    in_valid = 0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/r4_bfly_seq.md
Name: r4_bfly_seq

Overview:
Sequencer that feeds the radix-4 butterfly datapath (R4_butter) one 4-point complex group at a time.
- Accepts a packed group plus twiddle-select bits over a valid/ready handshake and registers it.
- Holds the butterfly inputs stable while the butterfly emits X0..X3 serially on its single 4-bit real/imag output pair.
- Collects the four results into an output buffer and presents them downstream with valid/ready backpressure.
- Sits between the LA/Wishbone-facing test logic and the butterfly instance in user_project_wrapper.

Parameters:
- DW, 4, bit width of each real/imag sample component.
- BFLY_LAT, 2, cycles from butterfly inputs becoming stable to X0 appearing on bf_xro/bf_xio (legal range 1..15).
- NPT, 4, points per group; fixed radix, must be 4.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RST  in  1  synchronous, active-high reset.
- in_valid  in  1  input group valid.
- in_ready  out  1  block can accept a group.
- in_xr  in  4*DW  real parts; x0 in [DW-1:0], x3 in the MSBs.
- in_xi  in  4*DW  imag parts, same packing.
- in_c  in  3  twiddle selects {c3,c2,c1}.
- bf_xr  out  4*DW  to butterfly xr0..xr3.
- bf_xi  out  4*DW  to butterfly xi0..xi3.
- bf_c  out  3  to butterfly {c3,c2,c1}.
- bf_xro  in  DW  butterfly serial real output.
- bf_xio  in  DW  butterfly serial imag output.
- out_valid  out  1  result group valid.
- out_ready  in  1  downstream accepts the result.
- out_xr  out  4*DW  X0..X3 real parts, same packing as in_xr.
- out_xi  out  4*DW  X0..X3 imag parts.
- busy  out  1  high in any state except IDLE.
- grp_cnt  out  8  completed groups, wraps 255->0.

Behaviour:
- Interface: one clock, CLK. RST is synchronous and active-high.
- Reset values: in_ready=1; out_valid=0; busy=0; grp_cnt=0; bf_xr, bf_xi, bf_c, out_xr, out_xi all 0; state=IDLE; counters 0.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at cycle t, register in_xr/in_xi/in_c into bf_xr/bf_xi/bf_c (visible from t+1), load wcnt=BFLY_LAT-1, go WAIT.
  - WAIT: in_ready=0. Decrement wcnt each cycle; when wcnt==0 go CAP with kcnt=0.
  - CAP: capture bf_xro/bf_xio into out slot kcnt, increment kcnt. Capture cycles are t+1+BFLY_LAT+k, k=0..3. After slot 3 go OUT.
  - OUT: out_valid=1, data stable. On out_ready: out_valid drops next cycle, grp_cnt+1, state IDLE.
- Throughput: accept-to-out_valid latency is BFLY_LAT+5 cycles. Minimum group period is BFLY_LAT+6 cycles, because there is no accept in OUT.
- Held values:
  - bf_* hold from accept until the next accept and are not cleared on group completion.
  - out_xr/out_xi hold until overwritten by the next CAP.
- Backpressure: OUT persists indefinitely while out_ready=0; data and out_valid stay stable.
- Handshake:
  - in_valid is ignored outside IDLE.
  - in_valid is sampled only with in_ready=1, so there is no combinational ready/valid loop.
  - out_ready is ignored when out_valid=0.
- Reset mid-operation (any state): all outputs return to reset values on the next edge, the partial group is discarded, and grp_cnt clears.
- grp_cnt wraps modulo 256 with no flag.
- Arithmetic: none on data; the block only routes and stores. Counters are 4-bit (wcnt) and 2-bit (kcnt).

Decomposition:
- Package r4_bfly_pkg:
  - state enum {IDLE, WAIT, CAP, OUT}.
  - localparams NPT=4 and CW=3.
  - helper constants for slot indexing (k*DW).
- One sub-module r4_bfly_collect: 4-slot serial-to-parallel capture register with a write-enable and 2-bit slot index. The FSM stays in the top module.

Test Plan:
1. Reset, then check idle outputs: in_ready=1, out_valid=0, busy=0, grp_cnt=0, bf_*=0.
2. Single group, BFLY_LAT=2:
   - Stimulus: accept at cycle 10 with in_xr=16'h4321, in_xi=16'h8765, in_c=3'b101. Model drives bf_xro=k+1 and bf_xio=k+9 on cycles 13..16.
   - Response: bf_xr=16'h4321 and bf_c=3'b101 from cycle 11; out_valid at cycle 17 with out_xr=16'h4321 and out_xi=16'hCBA9; grp_cnt=1 after out_ready.
3. Backpressure: hold out_ready=0 for 20 cycles. out_valid, out_xr and out_xi stay stable, in_ready stays 0, and a pending in_valid is not accepted until after release.
4. Back-to-back: keep in_valid high for 3 groups with out_ready=1. Accepts occur 8 cycles apart, and the 3 outputs match the model in order.
5. Reset mid-CAP: assert RST at the second capture cycle. The next cycle shows IDLE with out_valid=0 and grp_cnt=0; a fresh group then completes correctly.
6. Wrap: complete 256 groups; grp_cnt returns to 0, and the 257th group completes with grp_cnt=1.
